switch_sched: RTL and testbench

SWITCH_SCHED -- requirements
Module: switch_sched

---
 rtl/switch_sched.sv | 93 +++++++++
 tb/tb_switch_sched.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/switch_sched.sv
// switch_sched: timed toggle scheduler for a switch/relay control line
//   clk, rst                   : clock, asynchronous active-high reset
//   ld_valid/ld_ready, ld_time : load absolute toggle times into the table (IDLE only)
//   clr                        : empty the table (IDLE only)
//   start, abort               : begin a run / terminate a run
//   ctrl                       : registered switch control level
//   busy, done, ev_idx         : RUN flag, completion pulse, next pending entry
//   SWITCH_SCHED_REPEAT_EN     : when defined the schedule repeats until abort or rst
module switch_sched #(
  parameter bit INIT  = 1'b1,
  parameter int DEPTH = 8,
  parameter int TW    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [TW-1:0]            ld_time,
  input  logic                     clr,
  input  logic                     start,
  input  logic                     abort,
  output logic                     ctrl,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] ev_idx
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
`ifdef SWITCH_SCHED_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;
  state_t          state_q, state_d;
  logic [TW-1:0]   tbl_q [DEPTH];
  logic [TW-1:0]   timer_q, timer_d;
  logic [IW-1:0]   ev_idx_q, ev_idx_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ctrl_q, ctrl_d, done_q, done_d;
  logic            idle, run, go, ld_fire, fire, last;
  always_comb begin
    idle    = state_q == IDLE;
    run     = state_q == RUN;
    go      = idle & start & (count_q != '0);
    ld_fire = ld_valid & ld_ready;
    // abort masks the event so it wins over a toggle in the same cycle
    fire    = run & !abort & (timer_q >= tbl_q[ev_idx_q]);
    last    = (CW'(ev_idx_q) + CW'(1)) == count_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  always_comb
    state_d = go                    ? RUN  :
              (run & abort)         ? IDLE :
              (fire & last & !REP)  ? FIN  :
              (state_q == FIN)      ? IDLE : state_q;
  always_comb begin
    count_d  = (idle & clr) ? '0 : ld_fire ? count_q + CW'(1) : count_q;
    // in repeat mode the last event restarts the schedule on the same edge
    timer_d  = (go | (fire & last & REP))    ? '0 :
               (run & (timer_q != '1))       ? timer_q + TW'(1) : timer_q;
    ev_idx_d = (!run | abort | (fire & last)) ? '0 :
               fire ? ev_idx_q + IW'(1) : ev_idx_q;
    ctrl_d   = (go | (run & abort) | (fire & last & REP)) ? INIT :
               fire ? !ctrl_q : ctrl_q;
    done_d   = REP ? (fire & last) : (state_q == FIN);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      timer_q  <= '0;
      ev_idx_q <= '0;
      count_q  <= '0;
      ctrl_q   <= INIT;
      done_q   <= 1'b0;
    end else begin
      timer_q  <= timer_d;
      ev_idx_q <= ev_idx_d;
      count_q  <= count_d;
      ctrl_q   <= ctrl_d;
      done_q   <= done_d;
    end
  always_ff @(posedge clk)
    if (ld_fire) tbl_q[count_q[IW-1:0]] <= ld_time;
  always_comb begin
    ld_ready = idle & !start & !clr & (count_q < CW'(DEPTH));
    busy     = run;
    ctrl     = ctrl_q;
    done     = done_q;
    ev_idx   = ev_idx_q;
  end
endmodule

// File: tb/tb_switch_sched.sv
// tb_switch_sched: scoreboard bench for switch_sched with directed schedules
module tb_switch_sched;
  localparam int TW = 16;
  localparam int S_CTRL = 0, S_DONE = 1, S_BUSY = 2, S_RDY = 3, S_IDX = 4;
  logic          clk = 1'b0, rst = 1'b1, ld_valid = 1'b0, clr = 1'b0, start = 1'b0, abort = 1'b0;
  logic [TW-1:0] ld_time = '0;
  logic          ld_ready, ctrl, busy, done;
  logic [2:0]    ev_idx;
  switch_sched #(.INIT(1'b1), .DEPTH(8), .TW(TW)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_time(ld_time),
    .clr(clr), .start(start), .abort(abort), .ctrl(ctrl), .busy(busy), .done(done),
    .ev_idx(ev_idx)
  );
  always #5 clk = ~clk;
  typedef struct {int cyc; int sel; int exp; string nm;} exp_t;
  exp_t q[$];
  int cyc = 0, checks = 0, failures = 0, t0 = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int act(int sel);
    case (sel)
      S_CTRL:  return int'(ctrl);
      S_DONE:  return int'(done);
      S_BUSY:  return int'(busy);
      S_RDY:   return int'(ld_ready);
      default: return int'(ev_idx);
    endcase
  endfunction
  task automatic expect_at(input int c, input int sel, input int v, input string nm);
    exp_t e;
    int i;
    e = '{c, sel, v, nm};
    i = q.size();
    while (i > 0 && q[i-1].cyc > c) i--;
    q.insert(i, e);
  endtask
  task automatic x(input int k, input int sel, input int v, input string nm);
    expect_at(t0 + k, sel, v, nm);
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        failures++;
        $display("FAIL %s: check for cycle %0d missed at cycle %0d", e.nm, e.cyc, cyc);
      end else if (act(e.sel) != e.exp) begin
        failures++;
        $display("FAIL %s cyc=%0d: got %0d expected %0d", e.nm, cyc, act(e.sel), e.exp);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input int t);
    ld_valid = 1'b1;
    ld_time  = TW'(t);
    tick();
    ld_valid = 1'b0;
  endtask
  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
  endtask
  task automatic clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    expect_at(cyc, S_CTRL, 1, "rst_ctrl");
    expect_at(cyc, S_DONE, 0, "rst_done");
    expect_at(cyc, S_BUSY, 0, "rst_busy");
    expect_at(cyc, S_IDX, 0, "rst_idx");
    expect_at(cyc, S_RDY, 1, "rst_ready");
`ifdef SWITCH_SCHED_REPEAT_EN
    load(2); load(4); go();
    x(0, S_BUSY, 1, "rep_busy");
    x(3, S_CTRL, 0, "rep_t1");
    x(4, S_CTRL, 0, "rep_hold");
    x(5, S_DONE, 1, "rep_done");
    x(5, S_CTRL, 1, "rep_init");
    x(5, S_IDX, 0, "rep_idx0");
    x(5, S_BUSY, 1, "rep_stay_run");
    x(6, S_DONE, 0, "rep_done_pulse");
    x(7, S_CTRL, 1, "rep_pre2");
    x(8, S_CTRL, 0, "rep_t2");
    x(8, S_IDX, 1, "rep_idx1");
    x(10, S_BUSY, 0, "rep_abort_busy");
    x(10, S_CTRL, 1, "rep_abort_ctrl");
    x(10, S_DONE, 0, "rep_abort_prio");
    repeat (9) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
`else
    load(3); load(7); go();
    x(0, S_BUSY, 1, "r1_busy");
    x(3, S_CTRL, 1, "r1_pre");
    x(4, S_CTRL, 0, "r1_t1");
    x(4, S_IDX, 1, "r1_idx");
    x(7, S_CTRL, 0, "r1_hold");
    x(8, S_CTRL, 1, "r1_t2");
    x(8, S_BUSY, 0, "r1_fin_busy");
    x(8, S_DONE, 0, "r1_early_done");
    x(9, S_DONE, 1, "r1_done");
    x(9, S_CTRL, 1, "r1_final");
    x(10, S_DONE, 0, "r1_pulse");
    x(10, S_IDX, 0, "r1_idle_idx");
    repeat (11) tick();
    clear();
    for (int i = 0; i < 8; i++) load(i + 1);
    expect_at(cyc, S_RDY, 0, "full_ready");
    ld_valid = 1'b1;
    ld_time  = '0;
    tick();
    ld_valid = 1'b0;
    go();
    x(1, S_CTRL, 1, "full_pre");
    x(2, S_CTRL, 0, "full_t1");
    x(3, S_IDX, 2, "full_idx");
    x(9, S_CTRL, 1, "full_t8");
    x(9, S_BUSY, 0, "full_fin");
    x(10, S_DONE, 1, "full_done");
    repeat (11) tick();
    clr = 1'b1;
    expect_at(cyc, S_RDY, 0, "clr_ready_low");
    tick();
    clr = 1'b0;
    expect_at(cyc, S_RDY, 1, "clr_ready_back");
    load(5); load(5); load(2); go();
    x(5, S_CTRL, 1, "cu_pre");
    x(6, S_CTRL, 0, "cu_t1");
    x(7, S_CTRL, 1, "cu_t2");
    x(8, S_CTRL, 0, "cu_t3");
    x(8, S_BUSY, 0, "cu_fin");
    x(9, S_DONE, 1, "cu_done");
    x(9, S_CTRL, 0, "cu_final");
    repeat (11) tick();
    clear();
    load(10); load(20); go();
    x(10, S_CTRL, 1, "ab_pre");
    x(11, S_CTRL, 0, "ab_t1");
    x(12, S_BUSY, 1, "ab_busy");
    x(13, S_CTRL, 1, "ab_init");
    x(13, S_BUSY, 0, "ab_idle");
    x(13, S_IDX, 0, "ab_idx");
    x(13, S_DONE, 0, "ab_no_done");
    x(14, S_DONE, 0, "ab_no_done2");
    repeat (12) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (3) tick();
    go();
    x(11, S_CTRL, 0, "re_t1");
    x(20, S_CTRL, 0, "re_hold");
    x(21, S_CTRL, 1, "re_t2");
    x(21, S_BUSY, 0, "re_fin");
    x(22, S_DONE, 1, "re_done");
    x(23, S_DONE, 0, "re_pulse");
    repeat (24) tick();
    clear();
    load(2); load(7); go();
    x(3, S_CTRL, 0, "rr_t1");
    x(3, S_IDX, 1, "rr_idx");
    x(4, S_CTRL, 1, "rr_ctrl");
    x(4, S_BUSY, 0, "rr_busy");
    x(4, S_IDX, 0, "rr_idx0");
    x(4, S_DONE, 0, "rr_done");
    x(4, S_RDY, 1, "rr_ready");
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_at(cyc, S_BUSY, 0, "rr_start_ignored");
    expect_at(cyc + 5, S_BUSY, 0, "rr_still_idle");
    expect_at(cyc + 5, S_CTRL, 1, "rr_no_toggle");
    repeat (6) tick();
`endif
    for (int i = 0; i < 40 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d checks still pending, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
